// File: rtl/mod_codec_init_seq_pkg.sv
// Shared types, WM8731 register map and the default codec init table
// used by the codec init sequencer and its table ROM.
package mod_codec_init_seq_pkg;

  // One codec register write: 7-bit register address plus 9-bit data.
  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } codec_write_t;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } seq_state_t;

  // WM8731 register addresses.
  localparam logic [6:0] WM_LLIN   = 7'h00;
  localparam logic [6:0] WM_RLIN   = 7'h01;
  localparam logic [6:0] WM_LHP    = 7'h02;
  localparam logic [6:0] WM_RHP    = 7'h03;
  localparam logic [6:0] WM_APATH  = 7'h04;
  localparam logic [6:0] WM_DPATH  = 7'h05;
  localparam logic [6:0] WM_PWR    = 7'h06;
  localparam logic [6:0] WM_IFACE  = 7'h07;
  localparam logic [6:0] WM_SRATE  = 7'h08;
  localparam logic [6:0] WM_ACTIVE = 7'h09;
  localparam logic [6:0] WM_RESET  = 7'h0F;

  // Fault code reported when the master never answers a write.
  localparam logic [3:0] FAULT_TIMEOUT = 4'he;

  // Number of entries in the built-in table; indices past it read as zero.
  localparam int INIT_DEPTH = 10;

  // Default bring-up table: reset, power, inputs, paths, format, rate, output, activate.
  function automatic codec_write_t init_table_entry(input logic [5:0] idx);
    codec_write_t e;
    case (idx)
      6'd0:    e = '{reg_addr: WM_RESET,  data: 9'h000};
      6'd1:    e = '{reg_addr: WM_PWR,    data: 9'h010};
      6'd2:    e = '{reg_addr: WM_LLIN,   data: 9'h017};
      6'd3:    e = '{reg_addr: WM_RLIN,   data: 9'h017};
      6'd4:    e = '{reg_addr: WM_APATH,  data: 9'h012};
      6'd5:    e = '{reg_addr: WM_DPATH,  data: 9'h000};
      6'd6:    e = '{reg_addr: WM_IFACE,  data: 9'h00A};
      6'd7:    e = '{reg_addr: WM_SRATE,  data: 9'h000};
      6'd8:    e = '{reg_addr: WM_LHP,    data: 9'h079};
      6'd9:    e = '{reg_addr: WM_ACTIVE, data: 9'h001};
      default: e = '{reg_addr: 7'h00,     data: 9'h000};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mod_codec_init_seq_if.sv
// Request/acknowledge bus between the init sequencer and the I2C master.
interface mod_codec_init_seq_if;
  logic       i2c_req;
  logic [6:0] i2c_register;
  logic [8:0] i2c_data;
  logic       i2c_done;
  logic [3:0] i2c_fault_code;

  modport master (
    output i2c_req, i2c_register, i2c_data,
    input  i2c_done, i2c_fault_code
  );

  modport slave (
    input  i2c_req, i2c_register, i2c_data,
    output i2c_done, i2c_fault_code
  );
endinterface

// File: rtl/mod_codec_init_seq_rom.sv
// Combinational lookup of one codec init table entry by index.
module mod_codec_init_seq_rom
  import mod_codec_init_seq_pkg::*;
(
  input  logic [5:0]   index,
  output codec_write_t entry
);

  // Table lookup; out-of-table indices return an all-zero write.
  always_comb begin
    entry = init_table_entry(index);
  end

endmodule

// File: rtl/mod_codec_init_seq.sv
// Codec init sequencer: walks the init table into the I2C master, retrying
// faulted or timed-out writes, with an idle gap between writes.
module mod_codec_init_seq
  import mod_codec_init_seq_pkg::*;
#(
  parameter int NUM_REGS       = 10,
  parameter int MAX_RETRIES    = 3,
  parameter int GAP_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int AUTO_START     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_start,
  mod_codec_init_seq_if.master i2c,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fault,
  output logic [3:0]           o_fault_code,
  output logic [5:0]           o_index
);

  // Gap and timeout share one counter, sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [5:0]        LAST_IDX     = 6'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RTRY_LIMIT   = RTRY_W'(MAX_RETRIES);

  seq_state_t        state_r, state_n;
  logic [5:0]        index_r, index_n;
  logic [RTRY_W-1:0] retries_r, retries_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic              pending_r, pending_n;
  logic [3:0]        fault_code_r, fault_code_n;
  logic              launch_s;
  logic              fail_s;
  logic              req_r, busy_r, done_r, fault_r;
  logic [6:0]        reg_r;
  logic [8:0]        data_r;
  codec_write_t      entry_s;

  mod_codec_init_seq_rom u_rom (
    .index (index_n),
    .entry (entry_s)
  );

  // Next-state, index, retry and counter logic.
  always_comb begin
    state_n      = state_r;
    index_n      = index_r;
    retries_n    = retries_r;
    cnt_n        = cnt_r;
    pending_n    = pending_r;
    fault_code_n = fault_code_r;
    launch_s     = 1'b0;
    fail_s       = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (pending_r || i_start) launch_s = 1'b1;
        else                      launch_s = 1'b0;
      end
      S_DONE, S_FAULT: begin
        if (i_start) launch_s = 1'b1;
        else         launch_s = 1'b0;
      end
      S_ISSUE: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        // A done pulse wins over a coincident timeout.
        if (i2c.i2c_done) begin
          if (i2c.i2c_fault_code == 4'h0) begin
            if (index_r == LAST_IDX) begin
              state_n = S_DONE;
            end else begin
              index_n   = index_r + 6'd1;
              retries_n = '0;
              cnt_n     = '0;
              state_n   = S_GAP;
            end
          end else begin
            fault_code_n = i2c.i2c_fault_code;
            fail_s       = 1'b1;
          end
        end else if (cnt_r == TIMEOUT_LAST) begin
          fault_code_n = FAULT_TIMEOUT;
          fail_s       = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_r == GAP_LAST) state_n = S_ISSUE;
        else                   cnt_n   = cnt_r + CNT_W'(1);
      end
      default: state_n = S_IDLE;
    endcase

    // A failed write is re-issued after a gap until the retry budget runs out.
    if (fail_s) begin
      if (retries_r < RTRY_LIMIT) begin
        retries_n = retries_r + RTRY_W'(1);
        cnt_n     = '0;
        state_n   = S_GAP;
      end else begin
        state_n = S_FAULT;
      end
    end else begin
      retries_n = retries_n;
    end

    // Launch restarts the whole table and clears the previous outcome.
    if (launch_s) begin
      state_n      = S_ISSUE;
      index_n      = 6'd0;
      retries_n    = '0;
      cnt_n        = '0;
      pending_n    = 1'b0;
      fault_code_n = 4'h0;
    end else begin
      pending_n = pending_n;
    end
  end

  // State, counters and registered outputs; write payload latched on entry to ISSUE.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_r      <= S_IDLE;
      index_r      <= 6'd0;
      retries_r    <= '0;
      cnt_r        <= '0;
      pending_r    <= (AUTO_START != 0);
      fault_code_r <= 4'h0;
      req_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
      reg_r        <= 7'h00;
      data_r       <= 9'h000;
    end else begin
      state_r      <= state_n;
      index_r      <= index_n;
      retries_r    <= retries_n;
      cnt_r        <= cnt_n;
      pending_r    <= pending_n;
      fault_code_r <= fault_code_n;
      req_r        <= (state_n == S_ISSUE);
      busy_r       <= (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_GAP);
      done_r       <= (state_n == S_DONE);
      fault_r      <= (state_n == S_FAULT);
      if (state_n == S_ISSUE) begin
        reg_r  <= entry_s.reg_addr;
        data_r <= entry_s.data;
      end
    end
  end

  assign i2c.i2c_req      = req_r;
  assign i2c.i2c_register = reg_r;
  assign i2c.i2c_data     = data_r;
  assign o_busy           = busy_r;
  assign o_done           = done_r;
  assign o_fault          = fault_r;
  assign o_fault_code     = fault_code_r;
  assign o_index          = index_r;

endmodule
